// File: rtl/jk_drive_sequencer.sv
// rtl/jk_drive_sequencer.sv - command FIFO and J/K replay sequencer for a JK_ff bank
//
// Purpose:
//   Buffers HOLD/SET/CLEAR/TOGGLE commands in a small FIFO and replays each one
//   on the J/K inputs of the selected lanes for cmd_count+1 cycles. A shadow copy
//   of the downstream flop outputs is kept for checking and debug.
//
// Ports:
//   clk        - rising-edge clock shared with the JK_ff bank
//   rst_n      - asynchronous active-low reset
//   cmd_valid  - command present
//   cmd_ready  - FIFO can accept (not full)
//   cmd_op     - 0=HOLD 1=SET 2=CLEAR 3=TOGGLE
//   cmd_mask   - lanes the command applies to
//   cmd_count  - extra repeat cycles (drive length = cmd_count+1)
//   j_out      - registered J inputs to the bank
//   k_out      - registered K inputs to the bank
//   q_shadow   - predicted Q of each lane after the last applied edge
//   busy       - high while a command is being driven
//   fifo_level - number of queued entries, 0..DEPTH

module jk_drive_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_mask,
  input  logic [CNT_W-1:0]         cmd_count,
  output logic [WIDTH-1:0]         j_out,
  output logic [WIDTH-1:0]         k_out,
  output logic [WIDTH-1:0]         q_shadow,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  logic [1:0]       op_mem   [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  state_t           state;
  logic [CNT_W-1:0] remaining;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_mask;
  logic [WIDTH-1:0] head_j;
  logic [WIDTH-1:0] head_k;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign cmd_ready  = !fifo_full;

  // Push is gated by the registered full flag, so a simultaneous pop never
  // makes room for a push in the same edge.
  assign push = cmd_valid && !fifo_full;

  // Pop whenever idle, or on the last cycle of the current drive, so that
  // back-to-back commands run without an idle gap.
  assign pop = !fifo_empty && ((state == S_IDLE) || (remaining == '0));

  assign head_op   = op_mem[rd_ptr];
  assign head_mask = mask_mem[rd_ptr];

  // Lane encoding: HOLD 00, SET 01, CLEAR 10, TOGGLE 11 as {J,K}.
  assign head_j = head_op[1] ? head_mask : '0;
  assign head_k = head_op[0] ? head_mask : '0;

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      mask_mem[wr_ptr] <= cmd_mask;
      cnt_mem[wr_ptr]  <= cmd_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      j_out     <= '0;
      k_out     <= '0;
      busy      <= 1'b0;
      q_shadow  <= '0;
    end else begin
      // Per lane: 00 hold, 01 -> 1, 10 -> 0, 11 invert.
      q_shadow <= (~j_out & (k_out | q_shadow)) | (j_out & k_out & ~q_shadow);

      if (pop) begin
        state     <= S_DRIVE;
        busy      <= 1'b1;
        remaining <= cnt_mem[rd_ptr];
        j_out     <= head_j;
        k_out     <= head_k;
      end else if (state == S_DRIVE) begin
        if (remaining != '0) begin
          remaining <= remaining - CNT_W'(1);
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
          j_out <= '0;
          k_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// tb/tb_jk_drive_sequencer.sv - self-checking bench for jk_drive_sequencer

module tb_jk_drive_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] q_shadow;
  logic             busy;
  logic [LW-1:0]    fifo_level;

  always #5 clk = ~clk;

  jk_drive_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_count(cmd_count),
    .j_out(j_out), .k_out(k_out), .q_shadow(q_shadow), .busy(busy),
    .fifo_level(fifo_level)
  );

  // Attached JK_ff bank driven by the DUT's J/K outputs.
  logic [WIDTH-1:0] bank_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_out[i], k_out[i]})
          2'b01:   bank_q[i] <= 1'b1;
          2'b10:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] count;
  } cmd_t;

  typedef struct {
    logic             rst;
    logic             v;
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    logic [WIDTH-1:0] eq;
    logic             eb;
    logic             er;
    int               el;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of pending commands plus the command in flight,
  // tracked as the number of drive cycles it still has to occupy.
  cmd_t             mq[$];
  int               m_left;
  logic [WIDTH-1:0] m_j, m_k, m_q;

  function automatic cmd_t mk(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                              input logic [CNT_W-1:0] cnt);
    cmd_t c;
    c.op = op; c.mask = mask; c.count = cnt;
    return c;
  endfunction

  function automatic logic [2*WIDTH-1:0] enc(input cmd_t c);
    case (c.op)
      2'd0:    return {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
      2'd1:    return {{WIDTH{1'b0}}, c.mask};
      2'd2:    return {c.mask, {WIDTH{1'b0}}};
      default: return {c.mask, c.mask};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_left = 0;
    m_j = '0; m_k = '0; m_q = '0;
  endtask

  task automatic model_edge(input logic v, input cmd_t c);
    bit   ready;
    cmd_t h;
    ready = (mq.size() < DEPTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (!m_j[i] && m_k[i])      m_q[i] = 1'b1;
      else if (m_j[i] && !m_k[i]) m_q[i] = 1'b0;
      else if (m_j[i] && m_k[i])  m_q[i] = ~m_q[i];
    end
    if (mq.size() > 0 && m_left <= 1) begin
      h = mq.pop_front();
      {m_j, m_k} = enc(h);
      m_left = int'(h.count) + 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_j = '0; m_k = '0; end
    end
    if (v && ready) mq.push_back(c);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic chk_all(input string tag);
    int el;
    bit eb, er;
    el = mq.size();
    eb = (m_left > 0);
    er = (mq.size() < DEPTH);
    checks++;
    if (j_out === m_j && k_out === m_k && q_shadow === m_q && busy === eb &&
        cmd_ready === er && int'(fifo_level) == el)
      passes++;
    else
      $display("FAIL %s @%0t: got j=%b k=%b q=%b busy=%b rdy=%b lvl=%0d, expected j=%b k=%b q=%b busy=%b rdy=%b lvl=%0d",
               tag, $time, j_out, k_out, q_shadow, busy, cmd_ready, fifo_level,
               m_j, m_k, m_q, eb, er, el);
  endtask

  // Apply one cycle of stimulus, advance the model across the same edge and compare.
  task automatic step(input string tag, input logic v, input cmd_t c);
    cmd_valid = v;
    cmd_op    = c.op;
    cmd_mask  = c.mask;
    cmd_count = c.count;
    @(posedge clk);
    #1;
    model_edge(v, c);
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  cmd_t idle_c;
  vec_t tbl[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    cmd_t t4[5];
    int   idx, drive_cycles, pushed;
    bit   ready_pre;

    idle_c = mk(2'd0, '0, '0);

    // Reset with stimulus active, then idle cycles.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_mask  = 4'b1111;
    cmd_count = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk_all("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle_after_reset", 1'b0, idle_c);

    // Table: SET drive length, then reset and back-to-back TOGGLEs.
    tbl[0]  = '{1'b1, 1'b1, 2'd1, 4'b0101, 8'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0101, 4'b0101, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0101, 4'b0101, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b1, 2'd3, 4'b1111, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b1, 2'd3, 4'b1111, 8'd0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 0};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0};
    for (int i = 0; i < 12; i++) begin
      rst_n     = tbl[i].rst;
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_mask  = tbl[i].mask;
      cmd_count = tbl[i].cnt;
      @(posedge clk);
      #1;
      checks++;
      if (j_out === tbl[i].ej && k_out === tbl[i].ek && q_shadow === tbl[i].eq &&
          busy === tbl[i].eb && cmd_ready === tbl[i].er && int'(fifo_level) == tbl[i].el)
        passes++;
      else
        $display("FAIL vec%0d: got j=%b k=%b q=%b busy=%b rdy=%b lvl=%0d, expected j=%b k=%b q=%b busy=%b rdy=%b lvl=%0d",
                 i, j_out, k_out, q_shadow, busy, cmd_ready, fifo_level,
                 tbl[i].ej, tbl[i].ek, tbl[i].eq, tbl[i].eb, tbl[i].er, tbl[i].el);
    end

    // Five pushes with valid held high behind a long command.
    do_reset();
    step("t4_long_push", 1'b1, mk(2'd2, 4'b1111, 8'd20));
    step("t4_long_pop", 1'b0, idle_c);
    t4[0] = mk(2'd1, 4'b0001, 8'd1);
    t4[1] = mk(2'd2, 4'b0010, 8'd0);
    t4[2] = mk(2'd3, 4'b0100, 8'd2);
    t4[3] = mk(2'd1, 4'b1000, 8'd0);
    t4[4] = mk(2'd3, 4'b1001, 8'd1);
    idx = 0;
    for (int n = 0; n < 200 && (idx < 5 || mq.size() > 0 || m_left > 0); n++) begin
      ready_pre = (mq.size() < DEPTH);
      step("t4_run", idx < 5, (idx < 5) ? t4[idx] : idle_c);
      if (idx < 5 && ready_pre) begin
        idx++;
        if (idx == 4) begin
          chk("t4_full_level", int'(fifo_level), 4);
          chk("t4_full_ready", int'(cmd_ready), 0);
        end
      end
    end
    chk("t4_accepted", idx, 5);
    chk("t4_drained_busy", int'(busy), 0);

    // Mid-drive reset with three queued entries.
    do_reset();
    step("t5_push0", 1'b1, mk(2'd2, 4'b1111, 8'd10));
    step("t5_push1", 1'b1, mk(2'd1, 4'b1111, 8'd1));
    step("t5_push2", 1'b1, mk(2'd3, 4'b0110, 8'd1));
    step("t5_push3", 1'b1, mk(2'd1, 4'b0011, 8'd1));
    step("t5_mid", 1'b0, idle_c);
    chk("t5_pre_level", int'(fifo_level), 3);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_j", int'(j_out), 0);
    chk("t5_rst_k", int'(k_out), 0);
    chk("t5_rst_level", int'(fifo_level), 0);
    chk("t5_rst_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("t5_after", 1'b0, idle_c);

    // Maximum count drives 2^CNT_W cycles.
    do_reset();
    step("cmax_push", 1'b1, mk(2'd1, 4'b0011, 8'd255));
    drive_cycles = 0;
    for (int n = 0; n < 300; n++) begin
      step("cmax_run", 1'b0, idle_c);
      if (busy) drive_cycles++;
    end
    chk("cmax_len", drive_cycles, 256);

    // Random commands against the model and the attached bank.
    do_reset();
    step("rnd_init", 1'b1, mk(2'd2, 4'b1111, 8'd0));
    pushed = 0;
    for (int n = 0; n < 40000 && pushed < 1000; n++) begin
      c.op    = 2'($urandom_range(0, 3));
      c.mask  = WIDTH'($urandom_range(0, 15));
      c.count = ($urandom_range(0, 99) == 0) ? CNT_W'($urandom_range(0, 255))
                                             : CNT_W'($urandom_range(0, 3));
      ready_pre = (mq.size() < DEPTH);
      step("rnd", $urandom_range(0, 3) != 0, c);
      if (cmd_valid && ready_pre) pushed++;
      chk("rnd_bank", int'(q_shadow), int'(bank_q));
    end
    chk("rnd_pushed", pushed, 1000);
    for (int n = 0; n < 2000 && (mq.size() > 0 || m_left > 0); n++)
      step("rnd_drain", 1'b0, idle_c);
    chk("rnd_drain_busy", int'(busy), 0);
    chk("rnd_final_bank", int'(q_shadow), int'(bank_q));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
